sdram_wr_packer: RTL and testbench
==================================

SDRAM_WR_PACKER -- requirements
Module: sdram_wr_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 16, data word width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 4, words per burst, matching the controller write-once burst.
REQ-003 SHALL have parameter DEPTH_BURSTS, default 4, buffer capacity in bursts (16 words).
REQ-004 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port inData, input, WORD_W, upstream word.
REQ-007 SHALL have port inValid, input, 1, inData valid this cycle.
REQ-008 SHALL have port inReady, output, 1, word accepted when inValid&inReady.
REQ-009 SHALL have port flush, input, 1, one-cycle request to zero-pad the current partial burst.
REQ-010 SHALL have port burstData, output, WORD_W x BURST_LEN unpacked array, oldest burst; element [0] is the earliest word received.
REQ-011 SHALL have port burstEnable, output, 1, drives the controller writeDataEnable.
REQ-012 SHALL have port burstTake, input, 1, driven by the controller writeDataClk; each high cycle pops one burst.
REQ-013 SHALL have port level, output, 5, words currently stored (0..16).
REQ-014 SHALL have port underrunErr, output, 1, sticky error flag.

Function
REQ-015 SHALL store words in a circular buffer of DEPTH_BURSTS*BURST_LEN entries, with a 4-bit word write pointer and a 2-bit burst read pointer, both wrapping modulo size.
REQ-016 SHALL drive inReady = (state==S_FILL) && (level<16), combinationally from registered state.
REQ-017 SHALL drive burstEnable = (level>=4), combinationally from registered level, so it is valid the same cycle level changes.
REQ-018 SHALL drive burstData from entries rdBurst*4+0..3 combinationally; contents are don't-care while burstEnable=0.
REQ-019 SHALL, on burstTake&burstEnable, advance rdBurst by 1 and lower level by 4 on the next edge.
REQ-020 SHALL ignore burstTake while burstEnable=0 (no pointer change) and set underrunErr.
REQ-021 SHALL apply a simultaneous push and take as level+1-4 in a single cycle.
REQ-022 SHALL implement an FSM with states S_FILL and S_PAD.
REQ-023 SHALL go S_FILL->S_PAD when flush=1 and level%4!=0; flush with level%4==0 has no effect.
REQ-024 SHALL, in S_PAD, write one zero word per cycle with inReady=0, and return to S_FILL on the cycle the write pointer reaches a multiple of 4.
REQ-025 SHALL latency-guarantee that a word accepted at edge N is visible in burstData or level at edge N+1; no other pipeline delay exists.
REQ-026 SHALL never overflow: padding always fits, since level%4!=0 implies level<16.
REQ-027 SHALL ignore flush while in S_PAD.

Reset
REQ-028 SHALL, on reset, clear pointers to 0, set level=0, state=S_FILL, and underrunErr=0; outputs are then inReady=1 and burstEnable=0.
REQ-029 SHALL, on reset asserted mid-burst or mid-pad, discard all stored data immediately; storage contents are not cleared.

Structure
REQ-030 SHALL place WORD_W, BURST_LEN, DEPTH_BURSTS defaults and the packer state typedef in shared package sdram_pkg, alongside the controller's status enum.
REQ-031 SHALL have one natural sub-module, sdram_wbuf_mem: write port 1 word, read port BURST_LEN words, no reset.

Verification
REQ-032 SHALL verify: reset, then push 0x0001..0x0004 on 4 consecutive cycles -> burstEnable=1 one edge after the 4th, burstData={1,2,3,4}, level=4.
REQ-033 SHALL verify: push 16 words with no take -> inReady=0 at level=16; a 17th word is not accepted; one burstTake -> level=12 and inReady=1.
REQ-034 SHALL verify: push 0xAAAA,0xBBBB then flush -> inReady=0 for 2 cycles, burstData={AAAA,BBBB,0,0}, back to S_FILL.
REQ-035 SHALL verify: level=4, simultaneous push 0x0005 and burstTake -> level=1 and burstEnable=0.
REQ-036 SHALL verify: burstTake with level=2 -> level stays 2 and underrunErr=1 until reset.
REQ-037 SHALL verify: push 20 words taking a burst every 4 -> pointer wrap yields in-order bursts {17,18,19,20} last.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM defaults, write-packer state and controller status types
package sdram_pkg;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_DEPTH_BURSTS = 4;
  typedef enum logic {S_FILL, S_PAD} pack_state_t;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ACTIVE, ST_WRITE, ST_READ, ST_REFRESH} ctrl_status_t;
endpackage

// File: rtl/sdram_wbuf_mem.sv
// sdram_wbuf_mem: word-wide write port, burst-wide combinational read port, no reset
module sdram_wbuf_mem #(
  parameter int WORD_W = 16,
  parameter int BURST_LEN = 4,
  parameter int DEPTH_BURSTS = 4
) (
  input  logic                                        clock,
  input  logic                                        wr_en,
  input  logic [$clog2(DEPTH_BURSTS*BURST_LEN)-1:0]   wr_addr,
  input  logic [WORD_W-1:0]                           wr_data,
  input  logic [$clog2(DEPTH_BURSTS)-1:0]             rd_burst,
  output logic [WORD_W-1:0]                           rd_data [BURST_LEN]
);
  localparam int BO_W = $clog2(BURST_LEN);
  logic [WORD_W-1:0] mem [DEPTH_BURSTS*BURST_LEN];
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  for (genvar i = 0; i < BURST_LEN; i++) begin : g_rd
    assign rd_data[i] = mem[{rd_burst, BO_W'(i)}];
  end
endmodule

// File: rtl/sdram_wr_packer.sv
// sdram_wr_packer: packs upstream words into zero-padded bursts for the SDRAM write path
module sdram_wr_packer
  import sdram_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int DEPTH_BURSTS = DEF_DEPTH_BURSTS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] inData,
  input  logic              inValid,
  output logic              inReady,
  input  logic              flush,
  output logic [WORD_W-1:0] burstData [BURST_LEN],
  output logic              burstEnable,
  input  logic              burstTake,
  output logic [4:0]        level,
  output logic              underrunErr
);
  localparam int DEPTH = DEPTH_BURSTS * BURST_LEN;
  localparam int WP_W = $clog2(DEPTH);
  localparam int RB_W = $clog2(DEPTH_BURSTS);
  pack_state_t state, state_nxt;
  logic [WP_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [RB_W-1:0] rd_burst;
  logic [WORD_W-1:0] wr_data;
  logic wr_en, take, partial;
  assign inReady = state == S_FILL && level < 5'(DEPTH);
  assign burstEnable = level >= 5'(BURST_LEN);
  assign take = burstTake & burstEnable;
  assign wr_en = state == S_PAD || (inValid && inReady);
  assign wr_data = state == S_PAD ? '0 : inData;
  assign wr_ptr_nxt = wr_ptr + WP_W'(wr_en);
  // judged after this cycle's write so a push coinciding with flush is padded correctly
  assign partial = (int'(wr_ptr_nxt) % BURST_LEN) != 0;
  always_comb begin
    state_nxt = state;
    state_nxt = state == S_PAD ? (partial ? S_PAD : S_FILL) : (flush && partial ? S_PAD : S_FILL);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_FILL;
      wr_ptr <= '0;
      rd_burst <= '0;
      level <= '0;
      underrunErr <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_burst <= rd_burst + RB_W'(take);
      level <= level + 5'(wr_en) - (take ? 5'(BURST_LEN) : 5'd0);
      underrunErr <= underrunErr | (burstTake & ~burstEnable);
    end
  sdram_wbuf_mem #(.WORD_W(WORD_W), .BURST_LEN(BURST_LEN), .DEPTH_BURSTS(DEPTH_BURSTS)) u_mem (
    .clock(clock),
    .wr_en(wr_en),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_burst(rd_burst),
    .rd_data(burstData)
  );
endmodule

// File: tb/tb_sdram_wr_packer.sv
// tb_sdram_wr_packer: directed table, corner sequences and queue-model random checks
module tb_sdram_wr_packer;
  logic clock = 1'b0;
  logic reset, inValid, inReady, flush, burstEnable, burstTake, underrunErr;
  logic [15:0] inData;
  logic [15:0] burstData [4];
  logic [4:0] level;
  int n_cmp = 0, n_bad = 0;

  sdram_wr_packer dut (
    .clock(clock), .reset(reset), .inData(inData), .inValid(inValid), .inReady(inReady),
    .flush(flush), .burstData(burstData), .burstEnable(burstEnable), .burstTake(burstTake),
    .level(level), .underrunErr(underrunErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v; logic [15:0] d; logic f; logic t;
    logic [4:0] lvl; logic rdy, be, err, cbd;
    logic [15:0] bd [4];
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [15:0] d, logic f, logic t, logic [4:0] lvl,
                              logic rdy, logic be, logic err, logic cbd,
                              logic [15:0] b0, logic [15:0] b1, logic [15:0] b2, logic [15:0] b3);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.t = t; r.lvl = lvl; r.rdy = rdy; r.be = be; r.err = err; r.cbd = cbd;
    r.bd[0] = b0; r.bd[1] = b1; r.bd[2] = b2; r.bd[3] = b3;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [15:0] d, logic f, logic t);
    inValid = v; inData = d; flush = f; burstTake = t;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  logic [15:0] q[$];
  int pad;
  logic m_err;

  task automatic check_model(string tag);
    chk({tag, " level"}, 32'(level), 32'(q.size()));
    chk({tag, " inReady"}, 32'(inReady), 32'(pad == 0 && q.size() < 16));
    chk({tag, " burstEnable"}, 32'(burstEnable), 32'(q.size() >= 4));
    chk({tag, " underrunErr"}, 32'(underrunErr), 32'(m_err));
    if (q.size() >= 4)
      for (int i = 0; i < 4; i++) chk({tag, " burstData"}, 32'(burstData[i]), 32'(q[i]));
  endtask

  initial begin
    do_reset();
    chk("reset inReady", 32'(inReady), 1);
    chk("reset burstEnable", 32'(burstEnable), 0);
    chk("reset level", 32'(level), 0);
    chk("reset underrunErr", 32'(underrunErr), 0);

    tbl.push_back(mk(1, 16'h0001, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0003, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 4, 1, 1, 0, 1, 16'h1, 16'h2, 16'h3, 16'h4));
    tbl.push_back(mk(1, 16'h0005, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0006, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h7777, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 4, 1, 1, 1, 1, 16'h5, 16'h6, 16'h0, 16'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'hAAAA, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'hBBBB, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 4, 1, 1, 1, 1, 16'hAAAA, 16'hBBBB, 16'h0, 16'h0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 4, 1, 1, 1, 1, 16'hAAAA, 16'hBBBB, 16'h0, 16'h0));
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].f, tbl[k].t);
      step();
      chk($sformatf("vec%0d level", k), 32'(level), 32'(tbl[k].lvl));
      chk($sformatf("vec%0d inReady", k), 32'(inReady), 32'(tbl[k].rdy));
      chk($sformatf("vec%0d burstEnable", k), 32'(burstEnable), 32'(tbl[k].be));
      chk($sformatf("vec%0d underrunErr", k), 32'(underrunErr), 32'(tbl[k].err));
      if (tbl[k].cbd)
        for (int i = 0; i < 4; i++)
          chk($sformatf("vec%0d burstData[%0d]", k, i), 32'(burstData[i]), 32'(tbl[k].bd[i]));
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 16'(16'h0100 + i), 0, 0);
      step();
    end
    chk("full level", 32'(level), 16);
    chk("full inReady", 32'(inReady), 0);
    drive(1, 16'hDEAD, 0, 0);
    step();
    chk("17th rejected level", 32'(level), 16);
    chk("full head burstData[0]", 32'(burstData[0]), 32'h100);
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    chk("take from full level", 32'(level), 12);
    chk("take from full inReady", 32'(inReady), 1);
    chk("take from full burstData[0]", 32'(burstData[0]), 32'h104);

    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 16'(i), 0, 0);
      step();
      if (i % 4 == 0) begin
        drive(0, 0, 0, 0);
        chk("wrap level", 32'(level), 4);
        for (int j = 0; j < 4; j++) chk("wrap burstData", 32'(burstData[j]), 32'(i - 3 + j));
        drive(0, 0, 0, 1);
        step();
        chk("wrap drained", 32'(level), 0);
      end
    end
    chk("wrap underrunErr", 32'(underrunErr), 0);

    drive(1, 16'h1234, 0, 0);
    step();
    drive(0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0);
    chk("pad inReady", 32'(inReady), 0);
    #2 reset = 1'b1;
    #1;
    chk("async reset level", 32'(level), 0);
    chk("async reset inReady", 32'(inReady), 1);
    step();
    reset = 1'b0;
    step();
    chk("post reset level", 32'(level), 0);

    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      q.delete(); pad = 0; m_err = 1'b0;
      for (int c = 0; c < 150; c++) begin
        logic v, f, t, m_rdy, m_be;
        logic [15:0] d;
        check_model("rand");
        m_rdy = pad == 0 && q.size() < 16;
        m_be = q.size() >= 4;
        v = $urandom_range(2) != 0;
        d = 16'($urandom);
        f = $urandom_range(7) == 0;
        t = seg[0] ? $urandom_range(2) == 0 : (m_be && $urandom_range(1) == 0);
        drive(v, d, f, t);
        step();
        if (t && !m_be) m_err = 1'b1;
        if (t && m_be) repeat (4) void'(q.pop_front());
        if (pad > 0) begin
          q.push_back(16'h0);
          pad--;
        end else begin
          if (v && m_rdy) q.push_back(d);
          if (f && q.size() % 4 != 0) pad = 4 - q.size() % 4;
        end
      end
      check_model("rand end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
